// File: rtl/gate_tt_pkg.sv
// Shared codes for the gate truth-table identifier: gate identity codes and FSM states.
// Code 7 is reserved and never produced by the classifier.
package gate_tt_pkg;

    localparam int ID_W = 3;

    typedef enum logic [ID_W-1:0] {
        GATE_UNKNOWN  = 3'd0,
        GATE_AND      = 3'd1,
        GATE_NAND     = 3'd2,
        GATE_OR       = 3'd3,
        GATE_NOR      = 3'd4,
        GATE_XOR      = 3'd5,
        GATE_XNOR     = 3'd6,
        GATE_RESERVED = 3'd7
    } gate_id_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_CLASSIFY = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;

endpackage

// File: rtl/gate_tt_classify.sv
// Combinational classifier: maps a complete truth table (bit i = output for input vector i)
// to a gate identity code. Constant tables and anything else fall through to UNKNOWN.
module gate_tt_classify
    import gate_tt_pkg::*;
#(
    parameter int TT = 4
) (
    input  logic [TT-1:0]   tt,
    output logic [ID_W-1:0] gate_id
);

    localparam logic [TT-1:0] ONE   = TT'(1);
    localparam logic [TT-1:0] FULL  = '1;
    localparam logic [TT-1:0] AND_T = ONE << (TT - 1);
    localparam logic [TT-1:0] OR_T  = FULL & ~ONE;
    localparam logic [TT-1:0] NOR_T = ONE;

    logic [TT-1:0] xor_t;

    // XOR reference: each entry is the parity of its own input vector index.
    for (genvar i = 0; i < TT; i++) begin : g_parity
        localparam logic [7:0] IDX = 8'(i);
        assign xor_t[i] = ^IDX;
    end

    always_comb begin
        gate_id = GATE_UNKNOWN;
        if (tt == AND_T)
            gate_id = GATE_AND;
        else if (tt == ~AND_T)
            gate_id = GATE_NAND;
        else if (tt == OR_T)
            gate_id = GATE_OR;
        else if (tt == NOR_T)
            gate_id = GATE_NOR;
        else if (tt == xor_t)
            gate_id = GATE_XOR;
        else if (tt == ~xor_t)
            gate_id = GATE_XNOR;
    end

endmodule

// File: rtl/gate_tt_identifier.sv
// Observer that collects (input vector, output) samples from a gate under test, builds its
// truth table and reports the identified gate type, flagging contradictory samples.
module gate_tt_identifier
    import gate_tt_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int TT   = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_s,
    output logic [TT-1:0]   coverage,
    output logic [TT-1:0]   table_out,
    output logic            done,
    output logic            conflict,
    output logic [ID_W-1:0] gate_id
);

    state_e          state, state_next;
    logic            accept, seen, new_sample, mismatch;
    logic [TT-1:0]   vec_onehot, cov_next;
    logic [ID_W-1:0] class_id;

    // start wins over any sample offered in the same cycle.
    assign in_ready   = (state == ST_COLLECT) && !start;
    assign accept     = in_valid && in_ready;
    assign vec_onehot = {{(TT-1){1'b0}}, 1'b1} << in_vec;
    assign seen       = |(coverage & vec_onehot);
    assign new_sample = accept && !seen;
    assign mismatch   = accept && seen && ((|(table_out & vec_onehot)) != in_s);
    assign cov_next   = new_sample ? (coverage | vec_onehot) : coverage;

    gate_tt_classify #(.TT(TT)) u_classify (
        .tt      (table_out),
        .gate_id (class_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Leave COLLECT as soon as the accepted sample completes the table, so the
    // classifier sees the registered, complete table one cycle later.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_COLLECT;
        end else begin
            case (state)
                ST_IDLE:     state_next = ST_IDLE;
                ST_COLLECT: begin
                    if (mismatch)
                        state_next = ST_ERROR;
                    else if (&cov_next)
                        state_next = ST_CLASSIFY;
                end
                ST_CLASSIFY: state_next = ST_DONE;
                ST_DONE:     state_next = ST_DONE;
                ST_ERROR:    state_next = ST_ERROR;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coverage  <= '0;
            table_out <= '0;
            done      <= 1'b0;
            conflict  <= 1'b0;
            gate_id   <= GATE_UNKNOWN;
        end else if (start) begin
            coverage  <= '0;
            table_out <= '0;
            done      <= 1'b0;
            conflict  <= 1'b0;
            gate_id   <= GATE_UNKNOWN;
        end else begin
            if (new_sample) begin
                coverage <= cov_next;
                if (in_s)
                    table_out <= table_out | vec_onehot;
            end
            if (mismatch)
                conflict <= 1'b1;
            if (state == ST_CLASSIFY) begin
                done    <= 1'b1;
                gate_id <= class_id;
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_identifier.sv
// Self-checking bench for gate_tt_identifier: directed scenarios plus randomized sessions
// compared each cycle against a table-level reference model.
module tb_gate_tt_identifier;
    import gate_tt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, in_valid, in_s, in_ready;
    logic [1:0] in_vec;
    logic [3:0] coverage, table_out;
    logic       done, conflict;
    logic [2:0] gate_id;

    logic       start_3, in_valid_3, in_s_3, in_ready_3;
    logic [2:0] in_vec_3;
    logic [7:0] coverage_3, table_out_3;
    logic       done_3, conflict_3;
    logic [2:0] gate_id_3;

    gate_tt_identifier #(.N_IN(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_s(in_s), .coverage(coverage), .table_out(table_out),
        .done(done), .conflict(conflict), .gate_id(gate_id)
    );

    gate_tt_identifier #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_3), .in_valid(in_valid_3), .in_ready(in_ready_3),
        .in_vec(in_vec_3), .in_s(in_s_3), .coverage(coverage_3), .table_out(table_out_3),
        .done(done_3), .conflict(conflict_3), .gate_id(gate_id_3)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-vector seen/value arrays plus a session phase.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_CLASSIFY = 2, P_DONE = 3, P_ERROR = 4;
    bit m_cov[4];
    bit m_val[4];
    int m_phase;
    bit m_done, m_conf;
    int m_id;

    function automatic int ref_classify(input int t, input int tt);
        int full, and_t, xor_t;
        full  = (1 << tt) - 1;
        and_t = 1 << (tt - 1);
        xor_t = 0;
        for (int i = 0; i < tt; i++)
            if ($countones(i) % 2 == 1) xor_t |= (1 << i);
        if (t == and_t)              return 1;
        if (t == (full ^ and_t))     return 2;
        if (t == (full & ~1))        return 3;
        if (t == 1)                  return 4;
        if (t == xor_t)              return 5;
        if (t == (full ^ xor_t))     return 6;
        return 0;
    endfunction

    function automatic int m_cov_mask();
        int r = 0;
        for (int i = 0; i < 4; i++) if (m_cov[i]) r |= (1 << i);
        return r;
    endfunction

    function automatic int m_tab_mask();
        int r = 0;
        for (int i = 0; i < 4; i++) if (m_cov[i] && m_val[i]) r |= (1 << i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_cov[i] = 0; m_val[i] = 0; end
        m_phase = P_IDLE; m_done = 0; m_conf = 0; m_id = 0;
    endtask

    task automatic model_step(input bit st, input bit v, input int vec, input bit s);
        if (st) begin
            model_reset();
            m_phase = P_COLLECT;
        end else if (m_phase == P_COLLECT) begin
            if (v) begin
                if (!m_cov[vec]) begin
                    m_cov[vec] = 1; m_val[vec] = s;
                    if (m_cov_mask() == 15) m_phase = P_CLASSIFY;
                end else if (m_val[vec] != s) begin
                    m_conf = 1; m_phase = P_ERROR;
                end
            end
        end else if (m_phase == P_CLASSIFY) begin
            m_phase = P_DONE; m_done = 1; m_id = ref_classify(m_tab_mask(), 4);
        end
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, ".coverage"}, int'(coverage), m_cov_mask());
        checkOutput({tag, ".table"}, int'(table_out), m_tab_mask());
        checkOutput({tag, ".done"}, int'(done), int'(m_done));
        checkOutput({tag, ".conflict"}, int'(conflict), int'(m_conf));
        checkOutput({tag, ".gate_id"}, int'(gate_id), m_id);
    endtask

    // Drive one cycle on the N_IN=2 instance, then check against the model after the edge.
    task automatic applyStimulus(input bit st, input bit v, input int vec, input bit s);
        start = st; in_valid = v; in_vec = 2'(vec); in_s = s;
        #1;
        checkOutput("in_ready", int'(in_ready), int'(m_phase == P_COLLECT && !st));
        @(posedge clk);
        model_step(st, v, vec, s);
        #1;
        start = 0; in_valid = 0;
        check_all("cycle");
    endtask

    task automatic apply3(input bit st, input bit v, input int vec, input bit s);
        start_3 = st; in_valid_3 = v; in_vec_3 = 3'(vec); in_s_3 = s;
        @(posedge clk);
        #1;
        start_3 = 0; in_valid_3 = 0;
    endtask

    int target;
    bit s_bit;
    int vec_r;

    initial begin
        rst_n = 0; start = 0; in_valid = 0; in_vec = 0; in_s = 0;
        start_3 = 0; in_valid_3 = 0; in_vec_3 = 0; in_s_3 = 0;
        model_reset();
        #12;
        check_all("reset");
        checkOutput("reset.in_ready", int'(in_ready), 0);
        rst_n = 1;

        // NAND in order, done two edges after the completing sample
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(0, 1, 3, 0);
        checkOutput("nand.not_done_yet", int'(done), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("nand.gate_id", int'(gate_id), 2);
        checkOutput("nand.table", int'(table_out), 4'b0111);
        checkOutput("nand.coverage", int'(coverage), 4'b1111);

        // XOR out of order with a duplicate
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("xor.gate_id", int'(gate_id), 5);
        checkOutput("xor.conflict", int'(conflict), 0);

        // Conflict on vector 01, then start clears it
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("conf.conflict", int'(conflict), 1);
        checkOutput("conf.in_ready", int'(in_ready), 0);
        checkOutput("conf.table", int'(table_out), 4'b0010);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("conf.cleared", int'(conflict), 0);

        // Table 1100 follows input bit1: not a recognised gate
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 2, 1);
        applyStimulus(0, 1, 3, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("buf1.done", int'(done), 1);
        checkOutput("buf1.gate_id", int'(gate_id), 0);

        // Sample offered together with start is dropped
        applyStimulus(1, 1, 2, 1);
        checkOutput("startprio.coverage", int'(coverage), 0);

        // Async reset mid-collection, then a NOR session
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 2, 0);
        rst_n = 0;
        #2;
        model_reset();
        check_all("async_reset");
        checkOutput("async_reset.coverage", int'(coverage), 0);
        @(negedge clk);
        rst_n = 1;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 2, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("nor.gate_id", int'(gate_id), 4);

        // Randomized sessions; outputs mostly follow a chosen table with occasional flips
        target = 0;
        for (int n = 0; n < 400; n++) begin
            if (m_phase != P_COLLECT && $urandom_range(0, 3) == 0 || $urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 6))
                    0: target = 8;
                    1: target = 7;
                    2: target = 14;
                    3: target = 1;
                    4: target = 6;
                    5: target = 9;
                    default: target = int'($urandom_range(0, 15));
                endcase
                applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
            end else begin
                vec_r = int'($urandom_range(0, 3));
                s_bit = target[vec_r];
                if ($urandom_range(0, 19) == 0) s_bit = !s_bit;
                applyStimulus(0, $urandom_range(0, 2) != 0, vec_r, s_bit);
            end
        end

        // N_IN=3 AND gate on the second instance
        apply3(1, 0, 0, 0);
        for (int v = 0; v < 8; v++) apply3(0, 1, 7 - v, (7 - v) == 7);
        checkOutput("and3.classify_cycle_done", int'(done_3), 0);
        apply3(0, 0, 0, 0);
        checkOutput("and3.done", int'(done_3), 1);
        checkOutput("and3.gate_id", int'(gate_id_3), 1);
        checkOutput("and3.coverage", int'(coverage_3), 8'hFF);
        checkOutput("and3.table", int'(table_out_3), 8'h80);
        checkOutput("and3.conflict", int'(conflict_3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
